sha3_pad_lane_feeder: RTL and testbench
=======================================

Name: sha3_pad_lane_feeder

Overview:
- Upstream feeder for the Keccak permutation block.
- Accepts a byte-serial message and packs the bytes into 64-bit little-endian lanes.
- Applies SHA-3 multi-rate padding and zero-fills the capacity lanes.
- Emits complete 25-lane blocks in x-fastest order (lane k -> x=k%5, y=k/5) over a pushout/stopout handshake, with firstout marking lane 0 of each block.

Parameters:
- RATE_LANES, 17, number of rate lanes per block (17 = SHA3-256; legal range 1..24).
- STATE_LANES, 25, lanes per Keccak state; fixed, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pushin  in  1  input byte valid
- stopin  out  1  backpressure to the byte source
- lastin  in  1  qualifies din as the final message byte
- din  in  8  message byte
- pushout  out  1  lane valid
- stopout  in  1  backpressure from the permutation block
- firstout  out  1  high with lane 0 of every block
- lastout  out  1  high with lane 24 of the final block of a message
- dout  out  64  lane data

Behaviour:
- Reset values:
  - Outputs stopin, pushout, firstout, lastout, dout = 0.
  - State = FILL; byte index bi = 0; lane index li = 0.
- Transfers:
  - Input byte transfer occurs on pushin && !stopin.
  - Output lane transfer occurs on pushout && !stopout.
- Byte packing:
  - Byte bi lands in lane bits [8*bi+7 : 8*bi].
- Output buffer:
  - Single-entry lane output register.
  - A lane is loaded into it the cycle after its 8th byte is accepted (latency 1).
  - pushout holds, with dout/firstout/lastout stable, until transferred.
- stopin = 1 when any of:
  - the output register is full and stopout = 1;
  - state is not FILL.
- States:
  - FILL: accept bytes; a full lane goes to the output register; li++.
    - On lastin: go to PAD.
  - PAD (one cycle per lane):
    - Build the remaining lane: byte following the last message byte = 0x06; remaining bytes 0x00.
    - Rate byte 8*RATE_LANES-1 is OR'd with 0x80.
    - If the final message byte completed lane RATE_LANES-1, the pad occupies an entire new block: 0x06 at byte 0, 0x80 at the last rate byte.
    - Continue until li = RATE_LANES, then go to CAP.
  - CAP: emit zero lanes for li = RATE_LANES..24.
    - After lane 24 is transferred: li = 0; return to FILL.
    - Set lastout on lane 24 only if the block contains the pad.
  - Block rollover inside FILL: when li reaches RATE_LANES without lastin, go to CAP, then back to FILL for the next block.
- A lane is only built when the output register is empty or transferring that same cycle; no lane is ever dropped or duplicated.
- lastin on byte 7 of a lane: that lane is emitted unchanged and the pad starts at byte 0 of the next lane.
- lastin with pushin low is ignored.
- Zero-length messages are not supported.
- rst mid-block: immediate abort; the partial block is discarded; all counters clear; the next byte starts lane 0 with firstout.

Optional Feature:
- Macro: SHAKE_PAD_EN.
- With the macro defined: domain-separation byte = 0x1F (SHAKE); the collision case at the last rate byte yields 0x9F.
- Without it: 0x06 / 0x86 (SHA-3 hash).

Decomposition:
- Package sha3_pkg holds:
  - STATE_LANES = 25
  - the default RATE_LANES
  - pad constants PAD_SHA3 = 8'h06, PAD_SHAKE = 8'h1F, PAD_END = 8'h80
  - the state enum {FILL, PAD, CAP}
  - lane index to x/y helper functions
- Sub-module lane_packer holds the byte shift into the 64-bit lane, the byte counter and the full flag.
- Lane counter, FSM and output register stay in the top level.

Test Plan:
- Message "abc" (0x61,0x62,0x63, lastin on 0x63), stopout = 0:
  - lane 0 = 64'h0000_0000_0663_6261 with firstout;
  - lanes 1..15 = 0;
  - lane 16 = 64'h8000_0000_0000_0000;
  - lanes 17..24 = 0, lastout on lane 24.
- 136-byte message of 0xAA:
  - block 1: lanes 0..16 = 64'hAAAA_AAAA_AAAA_AAAA, lanes 17..24 = 0, lastout = 0;
  - block 2: lane 0 = 64'h06, lane 16 = 64'h8000_0000_0000_0000, lastout = 1.
- 135-byte message:
  - lane 16 = 64'h86AA_AAAA_AAAA_AAAA;
  - exactly one block is emitted.
- Backpressure: stopout held high for 10 cycles mid-block:
  - pushout and dout stay stable;
  - stopin rises;
  - no bytes are lost;
  - the lane sequence matches the stall-free run.
- rst pulse after 20 bytes, then "abc":
  - the output matches the first scenario exactly;
  - nothing from the aborted block appears.
- SHAKE_PAD_EN defined, "abc":
  - lane 0 = 64'h0000_0000_1F63_6261;
  - lane 16 = 64'h8000_0000_0000_0000.

Source files
------------

// File: rtl/sha3_pkg.sv
// -----------------------------------------------------------------------------
// sha3_pkg
// Shared definitions for the SHA-3 padding / lane feeder:
//   STATE_LANES        - lanes per Keccak state (fixed at 25)
//   RATE_LANES_DEFAULT - default rate in lanes (17 = SHA3-256)
//   PAD_SHA3/PAD_SHAKE - domain-separation pad bytes
//   PAD_END            - final-bit marker OR'd into the last rate byte
//   feed_state_e       - feeder FSM states
//   lane_x/lane_y      - lane index k -> Keccak (x, y) coordinates
// -----------------------------------------------------------------------------
package sha3_pkg;

    localparam int STATE_LANES        = 25;
    localparam int RATE_LANES_DEFAULT = 17;

    localparam logic [7:0] PAD_SHA3  = 8'h06;
    localparam logic [7:0] PAD_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        CAP  = 2'd2
    } feed_state_e;

    // Lanes leave in x-fastest order: k = x + 5*y.
    function automatic logic [2:0] lane_x(input logic [4:0] k);
        return 3'(k % 5'd5);
    endfunction

    function automatic logic [2:0] lane_y(input logic [4:0] k);
        return 3'(k / 5'd5);
    endfunction

endpackage

// File: rtl/lane_packer.sv
// -----------------------------------------------------------------------------
// lane_packer
// Collects message bytes into one 64-bit little-endian lane.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (byte counter only)
//   acc_i        - a message byte is accepted this cycle
//   clr_i        - restart the lane (byte counter back to 0)
//   din_i        - message byte
//   bi_o         - index of the next byte position in the lane
//   lane_o       - bytes collected so far (only bytes below bi_o are valid)
//   merged_o     - collected bytes with din_i inserted at position bi_o
//   full_o       - the accepted byte completes the lane (merged_o is whole)
// -----------------------------------------------------------------------------
module lane_packer
    import sha3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_i,
    input  logic        clr_i,
    input  logic [7:0]  din_i,
    output logic [2:0]  bi_o,
    output logic [63:0] lane_o,
    output logic [63:0] merged_o,
    output logic        full_o
);

    logic [2:0]  bi_q;
    logic [63:0] lane_q;

    // The counter wraps 7 -> 0 on its own when a lane completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bi_q <= 3'd0;
        end else if (clr_i) begin
            bi_q <= 3'd0;
        end else if (acc_i) begin
            bi_q <= bi_q + 3'd1;
        end
    end

    // Lane bytes need no reset: only positions below bi_q are ever consumed.
    always_ff @(posedge clk) begin
        if (acc_i) begin
            lane_q[{bi_q, 3'b000} +: 8] <= din_i;
        end
    end

    always_comb begin
        merged_o                       = lane_q;
        merged_o[{bi_q, 3'b000} +: 8]  = din_i;
    end

    assign full_o = acc_i && (bi_q == 3'd7);
    assign bi_o   = bi_q;
    assign lane_o = lane_q;

endmodule

// File: rtl/sha3_pad_lane_feeder.sv
// -----------------------------------------------------------------------------
// sha3_pad_lane_feeder
// Packs a byte-serial message into 64-bit little-endian lanes, appends SHA-3
// multi-rate padding, zero-fills the capacity lanes and emits whole 25-lane
// blocks (lane k -> x = k%5, y = k/5) to the Keccak permutation.
// Build option: define SHAKE_PAD_EN for the SHAKE domain byte (0x1F) instead
// of the SHA-3 hash byte (0x06).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   pushin    - input byte valid          stopin  - backpressure to source
//   lastin    - final message byte        din     - message byte
//   pushout   - lane valid                stopout - backpressure from sink
//   firstout  - lane 0 of every block     lastout - lane 24 of final block
//   dout      - lane data
// -----------------------------------------------------------------------------
module sha3_pad_lane_feeder
    import sha3_pkg::*;
#(
    parameter int RATE_LANES = RATE_LANES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    output logic        stopin,
    input  logic        lastin,
    input  logic [7:0]  din,
    output logic        pushout,
    input  logic        stopout,
    output logic        firstout,
    output logic        lastout,
    output logic [63:0] dout
);

    localparam logic [4:0] RATE_L = 5'(RATE_LANES);
    localparam logic [4:0] LAST_L = 5'(STATE_LANES - 1);

`ifdef SHAKE_PAD_EN
    localparam logic [7:0] PAD_DS = PAD_SHAKE;
`else
    localparam logic [7:0] PAD_DS = PAD_SHA3;
`endif

    feed_state_e state_q, state_d;
    logic [4:0]  li_q, li_d;
    logic        ds_pend_q, ds_pend_d;   // domain byte still to be placed
    logic        pad_blk_q, pad_blk_d;   // current block carries the pad

    logic        pushout_q, firstout_q, lastout_q;
    logic [63:0] dout_q;

    logic        byte_acc, out_xfer, out_free;
    logic        load, first_v, last_v, pk_clr;
    logic [63:0] lane_val, pad_lane;

    logic [2:0]  pk_bi;
    logic [63:0] pk_lane, pk_merged;
    logic        pk_full;

    assign out_xfer = pushout_q && !stopout;
    assign out_free = !pushout_q || !stopout;
    assign stopin   = (pushout_q && stopout) || (state_q != FILL);
    assign byte_acc = pushin && !stopin;

    lane_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .acc_i    (byte_acc),
        .clr_i    (pk_clr),
        .din_i    (din),
        .bi_o     (pk_bi),
        .lane_o   (pk_lane),
        .merged_o (pk_merged),
        .full_o   (pk_full)
    );

    // Pad lane: message bytes below bi kept, domain byte at bi (first pad lane
    // only), zeros above; the last rate lane also gets the end marker, which
    // merges with the domain byte when both land on byte 7.
    always_comb begin
        pad_lane = '0;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) < pk_bi) begin
                pad_lane[8*j +: 8] = pk_lane[8*j +: 8];
            end else if ((3'(j) == pk_bi) && ds_pend_q) begin
                pad_lane[8*j +: 8] = PAD_DS;
            end
        end
        if (li_q == RATE_L - 5'd1) begin
            pad_lane[63:56] = pad_lane[63:56] | PAD_END;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            li_q      <= 5'd0;
            ds_pend_q <= 1'b0;
            pad_blk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            li_q      <= li_d;
            ds_pend_q <= ds_pend_d;
            pad_blk_q <= pad_blk_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        li_d      = li_q;
        ds_pend_d = ds_pend_q;
        pad_blk_d = pad_blk_q;
        case (state_q)
            FILL: begin
                if (byte_acc && lastin) begin
                    ds_pend_d = 1'b1;
                end
                if (pk_full) begin
                    li_d = li_q + 5'd1;
                end
                // A message ending exactly on the rate boundary still has to
                // finish this block through CAP; its pad follows in a new block.
                if (pk_full && (li_q + 5'd1 == RATE_L)) begin
                    state_d = CAP;
                end else if (byte_acc && lastin) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (out_free) begin
                    ds_pend_d = 1'b0;
                    pad_blk_d = 1'b1;
                    li_d      = li_q + 5'd1;
                    if (li_q + 5'd1 == RATE_L) begin
                        state_d = CAP;
                    end
                end
            end
            CAP: begin
                if (out_free) begin
                    if (li_q == LAST_L) begin
                        li_d      = 5'd0;
                        pad_blk_d = 1'b0;
                        state_d   = ds_pend_q ? PAD : FILL;
                    end else begin
                        li_d = li_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output logic: lane build for the output register
    always_comb begin
        load     = 1'b0;
        lane_val = '0;
        pk_clr   = 1'b0;
        case (state_q)
            FILL: begin
                // stopin guarantees the output register is free when a byte
                // is accepted, so a completed lane can always be loaded.
                load     = pk_full;
                lane_val = pk_merged;
            end
            PAD: begin
                load     = out_free;
                lane_val = pad_lane;
                pk_clr   = out_free;
            end
            CAP: begin
                load     = out_free;
            end
            default: begin
                load     = 1'b0;
            end
        endcase
        first_v = (li_q == 5'd0);
        last_v  = (state_q == CAP) && (li_q == LAST_L) && pad_blk_q;
    end

    // Single-entry output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pushout_q  <= 1'b0;
            firstout_q <= 1'b0;
            lastout_q  <= 1'b0;
            dout_q     <= '0;
        end else if (load) begin
            pushout_q  <= 1'b1;
            firstout_q <= first_v;
            lastout_q  <= last_v;
            dout_q     <= lane_val;
        end else if (out_xfer) begin
            pushout_q  <= 1'b0;
            firstout_q <= 1'b0;
            lastout_q  <= 1'b0;
        end
    end

    assign pushout  = pushout_q;
    assign firstout = firstout_q;
    assign lastout  = lastout_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_sha3_pad_lane_feeder.sv
// -----------------------------------------------------------------------------
// tb_sha3_pad_lane_feeder
// Self-checking bench: a reference padder builds the expected lane stream for
// each message and queues it; a monitor pops and compares every lane transfer.
// -----------------------------------------------------------------------------
module tb_sha3_pad_lane_feeder;

    localparam int R = 17;
`ifdef SHAKE_PAD_EN
    localparam logic [7:0] DS = 8'h1F;
`else
    localparam logic [7:0] DS = 8'h06;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pushin = 1'b0;
    logic        lastin = 1'b0;
    logic        stopout = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        stopin, pushout, firstout, lastout;
    logic [63:0] dout;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [65:0] sb[$];
    logic [65:0] cap[$];
    logic [7:0]  msg[0:511];
    logic [7:0]  pbuf[0:1023];
    bit          ignore = 1'b0;
    bit          saw_stopin = 1'b0;
    bit          prev_stall = 1'b0;
    bit          busy = 1'b0;
    logic [65:0] prev_val = '0;

    sha3_pad_lane_feeder #(.RATE_LANES(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .pushin   (pushin),
        .stopin   (stopin),
        .lastin   (lastin),
        .din      (din),
        .pushout  (pushout),
        .stopout  (stopout),
        .firstout (firstout),
        .lastout  (lastout),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference padder: expected {firstout, lastout, dout} for an n-byte message.
    task automatic push_model(input int n);
        int total, nblk;
        logic [63:0] lane;
        total = ((n + 8*R) / (8*R)) * (8*R);
        for (int i = 0; i < total; i++) pbuf[i] = (i < n) ? msg[i] : 8'h00;
        pbuf[n]       = pbuf[n] | DS;
        pbuf[total-1] = pbuf[total-1] | 8'h80;
        nblk = total / (8*R);
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 25; k++) begin
                lane = '0;
                if (k < R) begin
                    for (int j = 0; j < 8; j++) lane[8*j +: 8] = pbuf[b*8*R + 8*k + j];
                end
                sb.push_back({(k == 0), (b == nblk-1) && (k == 24), lane});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit acc;
        pushin = 1'b1;
        din    = b;
        lastin = last;
        acc    = 1'b0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = !stopin;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 67'(acc), 67'(1));
        pushin = 1'b0;
        lastin = 1'b0;
    endtask

    task automatic send_msg(input int n);
        push_model(n);
        for (int i = 0; i < n; i++) send_byte(msg[i], i == n-1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !pushout) break;
            @(posedge clk);
            #1;
        end
        check("drain", 67'(sb.size()), 67'(0));
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_stopin",   67'(stopin),   67'(0));
        check("rst_pushout",  67'(pushout),  67'(0));
        check("rst_firstout", 67'(firstout), 67'(0));
        check("rst_lastout",  67'(lastout),  67'(0));
        check("rst_dout",     67'(dout),     67'(0));
    endtask

    task automatic load_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    endtask

    // Monitor: compare each transfer, check hold-while-stalled and stopin.
    always @(negedge clk) begin
        if (rst || ignore) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("hold", 67'({pushout, firstout, lastout, dout}), 67'({1'b1, prev_val}));
            if (pushout && stopout) begin
                check("stopin_bp", 67'(stopin), 67'(1));
                saw_stopin <= 1'b1;
            end
            if (pushout && !stopout) begin
                cap.push_back({firstout, lastout, dout});
                if (sb.size() == 0) check("extra_lane", 67'(1), 67'(0));
                else check("lane", 67'({firstout, lastout, dout}), 67'(sb.pop_front()));
            end
            prev_stall <= pushout && stopout;
            prev_val   <= {firstout, lastout, dout};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // "abc", no backpressure
        load_abc();
        cap.delete();
        send_msg(3);
        wait_drain();
        check("abc_count", 67'(cap.size()), 67'(25));
        check("abc_lane0",  67'(cap[0]),  67'({2'b10, 32'h0, DS, 24'h636261}));
        check("abc_lane16", 67'(cap[16]), 67'({2'b00, 64'h8000_0000_0000_0000}));
        check("abc_lane24", 67'(cap[24]), 67'({2'b01, 64'h0}));

        // 136 bytes of 0xAA: pad spills into a second block
        for (int i = 0; i < 136; i++) msg[i] = 8'hAA;
        cap.delete();
        send_msg(136);
        wait_drain();
        check("m136_count",  67'(cap.size()), 67'(50));
        check("m136_b1l16",  67'(cap[16]), 67'({2'b00, 64'hAAAA_AAAA_AAAA_AAAA}));
        check("m136_b1l24",  67'(cap[24]), 67'({2'b00, 64'h0}));
        check("m136_b2l0",   67'(cap[25]), 67'({2'b10, 56'h0, DS}));
        check("m136_b2l16",  67'(cap[41]), 67'({2'b00, 64'h8000_0000_0000_0000}));
        check("m136_b2l24",  67'(cap[49]), 67'({2'b01, 64'h0}));

        // 135 bytes: domain byte and end marker collide in the last rate byte
        cap.delete();
        send_msg(135);
        wait_drain();
        check("m135_count", 67'(cap.size()), 67'(25));
        check("m135_lane16", 67'(cap[16]), 67'({2'b00, DS | 8'h80, 56'hAA_AAAA_AAAA_AAAA}));

        // 10-cycle stall mid-block
        for (int i = 0; i < 60; i++) msg[i] = 8'(i * 7 + 3);
        cap.delete();
        fork
            send_msg(60);
            begin
                repeat (30) @(posedge clk);
                #1 stopout = 1'b1;
                repeat (10) @(posedge clk);
                #1 stopout = 1'b0;
            end
        join
        wait_drain();
        check("stall_stopin_seen", 67'(saw_stopin), 67'(1));
        check("stall_count", 67'(cap.size()), 67'(25));

        // Random backpressure over a two-block message
        for (int i = 0; i < 200; i++) msg[i] = 8'($urandom_range(0, 255));
        cap.delete();
        busy = 1'b1;
        fork
            begin
                send_msg(200);
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    @(posedge clk);
                    #1 stopout = ($urandom_range(0, 2) == 0);
                end
                stopout = 1'b0;
            end
        join
        wait_drain();
        check("rand_count", 67'(cap.size()), 67'(50));

        // Abort after 20 bytes, then "abc" must come out exactly as before
        ignore = 1'b1;
        for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i), 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        ignore = 1'b0;
        load_abc();
        cap.delete();
        send_msg(3);
        wait_drain();
        check("abort_count", 67'(cap.size()), 67'(25));
        check("abort_lane0", 67'(cap[0]), 67'({2'b10, 32'h0, DS, 24'h636261}));
        check("abort_lane24", 67'(cap[24]), 67'({2'b01, 64'h0}));

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
